iq_accum: RTL
=============

IQ_ACCUM -- requirements
Module: iq_accum

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, the signed input sample width.
REQ-002 SHALL have parameter WIN_DEFAULT, default 64, the window length in samples after reset.
REQ-003 SHALL have parameter WIN_MAX, default 1024, the largest programmable window length.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port clk_en  in  1  clock enable; when low, all state except the config registers holds.
REQ-007 SHALL have port sample  in  SAMPLE_W  signed ADC sample.
REQ-008 SHALL have port sample_valid  in  1  sample qualifier.
REQ-009 SHALL have port sample_ready  out  1  the block accepts a sample this cycle.
REQ-010 SHALL have port flush  in  1  aborts the current window.
REQ-011 SHALL have port cfg_we  in  1  window-length write strobe.
REQ-012 SHALL have port cfg_data  in  11  requested window length.
REQ-013 SHALL have port i  out  32  signed in-phase sum, feeding the downstream dataa.
REQ-014 SHALL have port q  out  32  signed quadrature sum, feeding the downstream datab (divisor).
REQ-015 SHALL have port q_zero  out  1  the raw Q sum of the window was zero.
REQ-016 SHALL have port valid  out  1  one-cycle pulse marking a new i/q pair.

Function
REQ-017 SHALL accept a sample only on a cycle where clk_en, sample_valid and sample_ready are all high.
REQ-018 SHALL use an fs/4 mixer driven by a 2-bit phase, counted per accepted sample and 0 at window start.
REQ-019 SHALL apply I weights +1, 0, -1, 0 and Q weights 0, +1, 0, -1 for phases 0..3.
REQ-020 SHALL sign-extend samples into 32-bit I and Q accumulators, with no saturation; SAMPLE_W+log2(WIN_MAX) <= 32 guarantees no overflow.
REQ-021 SHALL implement states IDLE, ACC and DUMP.
REQ-022 SHALL hold sample_ready high in IDLE and ACC and low in DUMP.
REQ-023 SHALL go from IDLE to ACC on the first accepted sample.
REQ-024 SHALL go from ACC to DUMP on the clock that accepts sample number win_len of the window, including that sample in the sums.
REQ-025 SHALL, in DUMP and with clk_en high, load i and q from the accumulators, set q_zero, pulse valid for exactly one cycle, clear the accumulators, count and phase, and return to ACC.
REQ-026 SHALL substitute q = 1 when the Q sum is zero and set q_zero = 1, so the downstream divider never sees a zero divisor.
REQ-027 SHALL hold i, q and q_zero stable between valid pulses.
REQ-028 SHALL keep valid low on every cycle except the DUMP-exit cycle.
REQ-029 SHALL, with clk_en low while in DUMP, stay in DUMP with valid low.
REQ-030 SHALL latch cfg_data into a pending register on cfg_we regardless of clk_en, clamping it to the range 4..WIN_MAX.
REQ-031 SHALL copy the pending value to the active win_len at each window start (DUMP exit or flush), and immediately if in IDLE.
REQ-032 SHALL, on flush with clk_en high, clear the accumulators, count and phase and enter IDLE, with no valid and i/q unchanged; a sample presented with flush is discarded.
REQ-033 SHALL let flush take priority over a simultaneous window completion.

Reset
REQ-034 SHALL, while reset is high, force state IDLE, accumulators, count and phase to 0, i = 0, q = 0, q_zero = 0, valid = 0, sample_ready = 1, and pending and active win_len = WIN_DEFAULT.
REQ-035 SHALL, on reset asserted mid-window, discard the partial sums with no valid pulse.

Verification
REQ-036 SHALL pass this check: win 4, samples 10, 20, 30, 40 -> one cycle later i = -20, q = -20, q_zero = 0, valid pulses once, sample_ready low for one cycle.
REQ-037 SHALL pass this check: win 4, samples 5, 0, 5, 0 -> i = 0, q = 1, q_zero = 1.
REQ-038 SHALL pass this check: win 4, samples 1, 2, 3, then flush with a fourth sample -> no valid, i/q unchanged; next samples 7, 1, 2, 3 -> i = 5, q = -2.
REQ-039 SHALL pass this check: cfg_we with 2 mid-window -> current window completes at the old length, the next at 4; cfg_data 2000 -> length 1024.
REQ-040 SHALL pass this check: clk_en toggled every other cycle with sample_valid held high -> sums identical to the continuous-enable case and valid pulses still exactly one cycle wide.
REQ-041 SHALL pass this check: reset asserted after 2 of 4 samples -> all outputs 0 asynchronously; after release, samples 10, 20, 30, 40 -> i = -20, q = -20.

Source files
------------

// File: rtl/iq_accum_if.sv
// Sample/config/result bundle for the iq_accum fs/4 I/Q accumulator.
interface iq_accum_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic                       sample_ready;
    logic                       flush;
    logic                       cfg_we;
    logic [10:0]                cfg_data;
    logic signed [31:0]         i;
    logic signed [31:0]         q;
    logic                       q_zero;
    logic                       valid;

    modport master (
        output sample, sample_valid, flush, cfg_we, cfg_data,
        input  sample_ready, i, q, q_zero, valid
    );

    modport slave (
        input  sample, sample_valid, flush, cfg_we, cfg_data,
        output sample_ready, i, q, q_zero, valid
    );
endinterface

// File: rtl/iq_accum.sv
// fs/4 digital mixer and windowed I/Q accumulator; dumps one i/q pair per window
// with a guaranteed non-zero q for the downstream divider.
module iq_accum #(
    parameter int SAMPLE_W    = 16,
    parameter int WIN_DEFAULT = 64,
    parameter int WIN_MAX     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    iq_accum_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [31:0] i_q, i_d, q_q, q_d;
    logic               q_zero_q, q_zero_d, valid_q, valid_d;
    logic [1:0]         phase_q, phase_d;
    logic [10:0]        count_q, count_d, win_len_q, win_len_d, pend_q, pend_d;
    logic [10:0]        cfg_clamped;
    logic signed [31:0] sample_ext;
    logic               sample_ready, accept, last, flush_now, dump_exit;

    // Handshake qualifiers; a sample presented together with flush is dropped.
    always_comb begin
        sample_ext = {{(32-SAMPLE_W){bus.sample[SAMPLE_W-1]}}, bus.sample};
        flush_now  = clk_en & bus.flush;
        accept     = clk_en & bus.sample_valid & sample_ready & ~bus.flush;
        last       = accept & ((count_q + 11'd1) == win_len_q);
        dump_exit  = clk_en & (state_q == DUMP) & ~bus.flush;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; flush outranks window completion.
    always_comb begin
        state_d = state_q;
        if (flush_now) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = last ? DUMP : ACC;
                ACC:     if (last) state_d = DUMP;
                DUMP:    if (clk_en) state_d = ACC;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: no samples taken while the dump is pending.
    always_comb begin
        sample_ready = (state_q != DUMP);
    end

    // Mixer/accumulator and result registers next-state.
    always_comb begin
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        count_d  = count_q;
        phase_d  = phase_q;
        i_d      = i_q;
        q_d      = q_q;
        q_zero_d = q_zero_q;
        valid_d  = 1'b0;
        if (flush_now) begin
            acc_i_d = '0;
            acc_q_d = '0;
            count_d = '0;
            phase_d = '0;
        end else if (dump_exit) begin
            i_d      = acc_i_q;
            q_zero_d = (acc_q_q == '0);
            q_d      = (acc_q_q == '0) ? 32'sd1 : acc_q_q;
            valid_d  = 1'b1;
            acc_i_d  = '0;
            acc_q_d  = '0;
            count_d  = '0;
            phase_d  = '0;
        end else if (accept) begin
            case (phase_q)
                2'd0:    acc_i_d = acc_i_q + sample_ext;
                2'd1:    acc_q_d = acc_q_q + sample_ext;
                2'd2:    acc_i_d = acc_i_q - sample_ext;
                default: acc_q_d = acc_q_q - sample_ext;
            endcase
            count_d = count_q + 11'd1;
            phase_d = phase_q + 2'd1;
        end
    end

    // Window-length config: pending latches on every write, active follows at window start.
    always_comb begin
        cfg_clamped = bus.cfg_data;
        if (bus.cfg_data < 11'd4)
            cfg_clamped = 11'd4;
        else if (32'(bus.cfg_data) > 32'(WIN_MAX))
            cfg_clamped = 11'(WIN_MAX);
        pend_d    = bus.cfg_we ? cfg_clamped : pend_q;
        win_len_d = win_len_q;
        if (flush_now || dump_exit || (state_q == IDLE))
            win_len_d = pend_d;
    end

    // Datapath and config registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            count_q   <= '0;
            phase_q   <= '0;
            i_q       <= '0;
            q_q       <= '0;
            q_zero_q  <= 1'b0;
            valid_q   <= 1'b0;
            pend_q    <= 11'(WIN_DEFAULT);
            win_len_q <= 11'(WIN_DEFAULT);
        end else begin
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            i_q       <= i_d;
            q_q       <= q_d;
            q_zero_q  <= q_zero_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            win_len_q <= win_len_d;
        end
    end

    assign bus.sample_ready = sample_ready;
    assign bus.i            = i_q;
    assign bus.q            = q_q;
    assign bus.q_zero       = q_zero_q;
    assign bus.valid        = valid_q;
endmodule
